tdm_demux16: RTL and testbench

TDM_DEMUX16 -- requirements
Module: tdm_demux16

---
 rtl/tdm_demux16_pkg.sv | 13 +
 rtl/tdm_demux16_demux_1to4.sv | 13 +
 rtl/tdm_demux16.sv | 166 ++++++++++++++++
 tb/tb_tdm_demux16.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux16_pkg.sv
// Shared definitions for the 16-slot TDM demultiplexer: state encodings and slot geometry.
package tdm_demux16_pkg;

   localparam int NUM_SLOTS = 16;
   localparam int SLOT_W    = 4;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      RECV   = 2'd1,
      PARITY = 2'd2
   } state_t;

endpackage

// File: rtl/tdm_demux16_demux_1to4.sv
// 1-to-4 decoder with enable; building block of the shadow write-enable tree.
module demux_1to4 (
   input  logic       i_en,
   input  logic [1:0] i_sel,
   output logic [3:0] o_y
);

   always_comb begin
      o_y = 4'b0000;
      if (i_en) o_y[i_sel] = 1'b1;
   end

endmodule

// File: rtl/tdm_demux16.sv
// Serial 16-slot TDM frame demultiplexer with frame_sync lock tracking.
// Optional trailing even-parity beat per frame when TDM_DEMUX_PARITY_EN is defined.
//
// state  | meaning
// HUNT   | unlocked; waiting for a valid beat carrying frame_sync
// RECV   | locked; collecting slots 0..15 into the shadow register
// PARITY | locked; next valid beat is the frame's even-parity bit
module tdm_demux16
   import tdm_demux16_pkg::*;
#(
   parameter int SYNC_LOSS_LIMIT = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 din,
   input  logic                 din_valid,
   input  logic                 frame_sync,
   output logic [NUM_SLOTS-1:0] dout,
   output logic                 dout_valid,
   output logic [SLOT_W-1:0]    slot,
   output logic                 locked,
   output logic                 sync_err,
   output logic                 parity_err
);

   localparam logic [3:0] MISS_LIM = SYNC_LOSS_LIMIT[3:0];

   state_t               r_state, w_state_nxt;
   logic [SLOT_W-1:0]    r_slot, w_slot_nxt, w_wr_idx;
   logic [3:0]           r_miss, w_miss_nxt, w_miss_inc;
   logic [NUM_SLOTS-1:0] r_shadow, w_shadow_nxt, w_we;
   logic [NUM_SLOTS-1:0] r_dout;
   logic                 r_dout_valid, r_sync_err;
   logic                 w_wr_en, w_pub, w_sync_err;
   logic [3:0]           w_l1_en;
`ifdef TDM_DEMUX_PARITY_EN
   logic                 r_par_err, w_par_err;
`endif

   // Two-level decoder tree: slot[3:2] picks the group, slot[1:0] the bit within it.
   demux_1to4 u_dmx_l1 (
      .i_en  (w_wr_en),
      .i_sel (w_wr_idx[3:2]),
      .o_y   (w_l1_en)
   );

   for (genvar g = 0; g < 4; g++) begin : g_l2
      demux_1to4 u_dmx_l2 (
         .i_en  (w_l1_en[g]),
         .i_sel (w_wr_idx[1:0]),
         .o_y   (w_we[4*g +: 4])
      );
   end

   // Publishing from the post-write shadow lets slot 15 land in dout on the same edge.
   assign w_shadow_nxt = (r_shadow & ~w_we) | (w_we & {NUM_SLOTS{din}});
   assign w_miss_inc   = r_miss + 4'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_slot_nxt  = r_slot;
      w_miss_nxt  = r_miss;
      w_wr_en     = 1'b0;
      w_wr_idx    = r_slot;
      w_pub       = 1'b0;
      w_sync_err  = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      w_par_err   = 1'b0;
`endif
      if (din_valid) begin
         case (r_state)
            HUNT: begin
               if (frame_sync) begin
                  w_wr_en     = 1'b1;
                  w_wr_idx    = '0;
                  w_slot_nxt  = 4'd1;
                  w_miss_nxt  = 4'd0;
                  w_state_nxt = RECV;
               end
            end
            RECV: begin
               if (frame_sync && r_slot != '0) begin
                  w_sync_err  = 1'b1;
                  w_wr_en     = 1'b1;
                  w_wr_idx    = '0;
                  w_slot_nxt  = 4'd1;
                  w_miss_nxt  = 4'd0;
               end else if (r_slot == '0 && !frame_sync && w_miss_inc == MISS_LIM) begin
                  w_state_nxt = HUNT;
                  w_slot_nxt  = '0;
                  w_miss_nxt  = 4'd0;
               end else begin
                  w_wr_en    = 1'b1;
                  w_slot_nxt = r_slot + 4'd1;
                  if (r_slot == '0) w_miss_nxt = frame_sync ? 4'd0 : w_miss_inc;
                  if (r_slot == 4'd15) begin
`ifdef TDM_DEMUX_PARITY_EN
                     w_state_nxt = PARITY;
`else
                     w_pub = 1'b1;
`endif
                  end
               end
            end
`ifdef TDM_DEMUX_PARITY_EN
            PARITY: begin
               w_state_nxt = RECV;
               if (frame_sync) begin
                  w_sync_err = 1'b1;
                  w_wr_en    = 1'b1;
                  w_wr_idx   = '0;
                  w_slot_nxt = 4'd1;
                  w_miss_nxt = 4'd0;
               end else begin
                  w_slot_nxt = '0;
                  if (din == ^r_shadow) w_pub     = 1'b1;
                  else                  w_par_err = 1'b1;
               end
            end
`endif
            default: begin
               w_state_nxt = HUNT;
               w_slot_nxt  = '0;
               w_miss_nxt  = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= HUNT;
         r_slot       <= '0;
         r_miss       <= 4'd0;
         r_shadow     <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_sync_err   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_slot       <= w_slot_nxt;
         r_miss       <= w_miss_nxt;
         r_shadow     <= w_shadow_nxt;
         r_dout_valid <= w_pub;
         r_sync_err   <= w_sync_err;
         if (w_pub) r_dout <= w_shadow_nxt;
      end
   end

`ifdef TDM_DEMUX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_par_err <= 1'b0;
      else        r_par_err <= w_par_err;
   end
   assign parity_err = r_par_err;
`else
   assign parity_err = 1'b0;
`endif

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign slot       = r_slot;
   assign locked     = (r_state != HUNT);
   assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_tdm_demux16.sv
// Directed self-checking bench for tdm_demux16 (honours TDM_DEMUX_PARITY_EN when defined).
module tb_tdm_demux16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        din = 1'b0;
   logic        din_valid = 1'b0;
   logic        frame_sync = 1'b0;
   logic [15:0] dout;
   logic        dout_valid;
   logic [3:0]  slot;
   logic        locked;
   logic        sync_err;
   logic        parity_err;

   int n_checks = 0;
   int n_fail   = 0;
   int vcnt     = 0;
   int scnt     = 0;
   int pcnt     = 0;

   tdm_demux16 #(.SYNC_LOSS_LIMIT(3)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .frame_sync (frame_sync),
      .dout       (dout),
      .dout_valid (dout_valid),
      .slot       (slot),
      .locked     (locked),
      .sync_err   (sync_err),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   // Pulse counters sample the value held through the preceding cycle.
   always @(posedge clk) begin
      if (dout_valid) vcnt <= vcnt + 1;
      if (sync_err)   scnt <= scnt + 1;
      if (parity_err) pcnt <= pcnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic beat(input logic d, input logic fs);
      din        = d;
      frame_sync = fs;
      din_valid  = 1'b1;
      @(negedge clk);
      din_valid  = 1'b0;
      frame_sync = 1'b0;
      din        = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_slots(input logic [15:0] data, input int first, input int last,
                             input logic sync_first, input logic gaps);
      for (int k = first; k <= last; k++) begin
         beat(data[k], sync_first && (k == first));
         if (gaps) idle(k % 4);
      end
   endtask

   task automatic send_tail(input logic [15:0] data);
`ifdef TDM_DEMUX_PARITY_EN
      beat(^data, 1'b0);
`endif
   endtask

   task automatic send_frame(input logic [15:0] data, input logic sync, input logic gaps);
      send_slots(data, 0, 15, sync, gaps);
      send_tail(data);
   endtask

   initial begin
      int v0;
      // reset state
      idle(1);
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_dout_valid", 32'(dout_valid), 32'h0);
      check("rst_slot", 32'(slot), 32'h0);
      check("rst_locked", 32'(locked), 32'h0);
      check("rst_sync_err", 32'(sync_err), 32'h0);
      check("rst_parity_err", 32'(parity_err), 32'h0);
      rst_n = 1'b1;
      idle(1);

      // HUNT discards beats without frame_sync
      beat(1'b1, 1'b0);
      beat(1'b1, 1'b0);
      check("hunt_slot", 32'(slot), 32'h0);
      check("hunt_locked", 32'(locked), 32'h0);

      // basic frame 0xA5C3
      beat(1'b1, 1'b1);
      check("lock_slot", 32'(slot), 32'h1);
      check("lock_locked", 32'(locked), 32'h1);
      send_slots(16'hA5C3, 1, 15, 1'b0, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
      check("pre_parity_valid", 32'(dout_valid), 32'h0);
`endif
      send_tail(16'hA5C3);
      check("a5c3_valid", 32'(dout_valid), 32'h1);
      check("a5c3_dout", 32'(dout), 32'hA5C3);
      check("a5c3_locked", 32'(locked), 32'h1);
      check("a5c3_slot", 32'(slot), 32'h0);
      idle(1);
      check("a5c3_pulse_end", 32'(dout_valid), 32'h0);
      idle(1);
      check("a5c3_vcnt", 32'(vcnt), 32'h1);

      // two frames with idle gaps between beats
      v0 = vcnt;
      send_frame(16'h1234, 1'b1, 1'b1);
      check("gap1_dout", 32'(dout), 32'h1234);
      send_frame(16'hFEDC, 1'b1, 1'b1);
      check("gap2_dout", 32'(dout), 32'hFEDC);
      idle(2);
      check("gap_vcnt", 32'(vcnt - v0), 32'h2);

      // misplaced frame_sync at slot 7
      v0 = vcnt;
      send_slots(16'h0000, 0, 6, 1'b1, 1'b0);
      check("pre_err_slot", 32'(slot), 32'h7);
      beat(1'b1, 1'b1);
      check("sync_err_pulse", 32'(sync_err), 32'h1);
      check("sync_err_slot", 32'(slot), 32'h1);
      check("sync_err_dout", 32'(dout), 32'hFEDC);
      idle(1);
      check("sync_err_end", 32'(sync_err), 32'h0);
      send_slots(16'h0F0F, 1, 15, 1'b0, 1'b0);
      send_tail(16'h0F0F);
      check("resync_valid", 32'(dout_valid), 32'h1);
      check("resync_dout", 32'(dout), 32'h0F0F);
      idle(2);
      check("resync_vcnt", 32'(vcnt - v0), 32'h1);
      check("resync_scnt", 32'(scnt), 32'h1);

      // flywheel then loss of lock after three sync-less frames
      v0 = vcnt;
      send_frame(16'h1111, 1'b0, 1'b0);
      check("fly1_dout", 32'(dout), 32'h1111);
      check("fly1_locked", 32'(locked), 32'h1);
      send_frame(16'h2222, 1'b0, 1'b0);
      check("fly2_dout", 32'(dout), 32'h2222);
      beat(1'b1, 1'b0);
      check("loss_locked", 32'(locked), 32'h0);
      check("loss_slot", 32'(slot), 32'h0);
      send_slots(16'hFFFF, 0, 15, 1'b0, 1'b0);
      idle(2);
      check("loss_vcnt", 32'(vcnt - v0), 32'h2);
      check("loss_dout_held", 32'(dout), 32'h2222);
      check("loss_still_hunt", 32'(locked), 32'h0);

`ifdef TDM_DEMUX_PARITY_EN
      // parity mismatch then match on frame 0x0001
      v0 = vcnt;
      send_slots(16'h0001, 0, 15, 1'b1, 1'b0);
      beat(1'b0, 1'b0);
      check("par_bad_err", 32'(parity_err), 32'h1);
      check("par_bad_valid", 32'(dout_valid), 32'h0);
      check("par_bad_dout", 32'(dout), 32'h2222);
      check("par_bad_slot", 32'(slot), 32'h0);
      send_slots(16'h0001, 0, 15, 1'b1, 1'b0);
      beat(1'b1, 1'b0);
      check("par_ok_err", 32'(parity_err), 32'h0);
      check("par_ok_valid", 32'(dout_valid), 32'h1);
      check("par_ok_dout", 32'(dout), 32'h0001);
      idle(2);
      check("par_vcnt", 32'(vcnt - v0), 32'h1);
      check("par_pcnt", 32'(pcnt), 32'h1);
`else
      check("no_parity_err", 32'(pcnt), 32'h0);
`endif

      // reset mid-frame at slot 9
      send_frame(16'hBEEF, 1'b1, 1'b0);
      send_slots(16'h0000, 0, 8, 1'b1, 1'b0);
      check("pre_rst_slot", 32'(slot), 32'h9);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_dout", 32'(dout), 32'h0);
      check("mid_rst_slot", 32'(slot), 32'h0);
      check("mid_rst_locked", 32'(locked), 32'h0);
      check("mid_rst_valid", 32'(dout_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      v0 = vcnt;
      send_slots(16'hFFFF, 0, 15, 1'b0, 1'b0);
      send_slots(16'hFFFF, 0, 7, 1'b0, 1'b0);
      idle(2);
      check("post_rst_vcnt", 32'(vcnt - v0), 32'h0);
      check("post_rst_locked", 32'(locked), 32'h0);
      check("post_rst_dout", 32'(dout), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
